cam_sccb_config: RTL and testbench



---
 rtl/cam_pkg.sv | 33 +++
 rtl/sccb_qtr_tick.sv | 29 ++
 rtl/cam_sccb_config.sv | 206 ++++++++++++++++++++
 tb/tb_cam_sccb_config.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera SCCB register loader.
package cam_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_GAP,
        ST_DELAY,
        ST_DONE
    } cam_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } tbl_entry_t;

    localparam logic [15:0] END_MARK     = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK   = 16'hF0F0;
    localparam logic [7:0]  DEF_DEV_ADDR = 8'h42;
    localparam int unsigned FRAME_BITS   = 27;

    // Three bytes, each followed by a released (logic 1) don't-care slot.
    function automatic logic [FRAME_BITS-1:0] sccb_frame(input logic [7:0] dev,
                                                        input tbl_entry_t entry);
        return {dev, 1'b1, entry.reg_addr, 1'b1, entry.value, 1'b1};
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Enable-gated divider producing a one-cycle pulse every QTR_DIV cycles.
module sccb_qtr_tick #(
    parameter int unsigned QTR_DIV = 125
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CW'(QTR_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick_c = en && (cnt == CW'(QTR_DIV - 1));

endmodule

// File: rtl/cam_sccb_config.sv
// Walks an external register ROM and writes each entry to the camera over SCCB.
module cam_sccb_config
    import cam_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SCCB_HZ      = 100_000,
    parameter logic [7:0]  DEV_ADDR     = DEF_DEV_ADDR,
    parameter int unsigned NUM_REGS     = 128,
    parameter int unsigned DELAY_CYCLES = 500_000,
    localparam int unsigned AW          = $clog2(NUM_REGS)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    output logic          sioc,
    output logic          siod_out,
    output logic          siod_oe,
    output logic          busy,
    output logic          done,
    output logic [7:0]    reg_count
);

    localparam int unsigned QTR_DIV = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned DW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    cam_state_e            state, state_d;
    logic [AW-1:0]         addr_d;
    logic                  sioc_d, oe_d, busy_d, done_d;
    logic [7:0]            cnt_d;
    logic [1:0]            qcnt, qcnt_d;
    logic [4:0]            bit_cnt, bit_d;
    logic [FRAME_BITS-1:0] shreg, sh_d;
    logic [DW-1:0]         dcnt, dcnt_d;
    logic                  adv;
    logic                  qtick_c;

    sccb_qtr_tick #(
        .QTR_DIV (QTR_DIV)
    ) u_qtr_tick (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .en     (busy),
        .tick_c (qtick_c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            tbl_addr  <= '0;
            sioc      <= 1'b1;
            siod_out  <= 1'b0;
            siod_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            reg_count <= '0;
            qcnt      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dcnt      <= '0;
        end else begin
            state     <= state_d;
            tbl_addr  <= addr_d;
            sioc      <= sioc_d;
            siod_out  <= 1'b0;
            siod_oe   <= oe_d;
            busy      <= busy_d;
            done      <= done_d;
            reg_count <= cnt_d;
            qcnt      <= qcnt_d;
            bit_cnt   <= bit_d;
            shreg     <= sh_d;
            dcnt      <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = tbl_addr;
        sioc_d  = sioc;
        oe_d    = siod_oe;
        busy_d  = busy;
        done_d  = done;
        cnt_d   = reg_count;
        qcnt_d  = qcnt;
        bit_d   = bit_cnt;
        sh_d    = shreg;
        dcnt_d  = dcnt;
        adv     = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                sioc_d = 1'b1;
                oe_d   = 1'b0;
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH:      state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_d = ST_DECODE;
            ST_DECODE: begin
                if (tbl_data == END_MARK) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (tbl_data == DELAY_MARK) begin
                    state_d = ST_DELAY;
                    dcnt_d  = '0;
                end else begin
                    sh_d    = sccb_frame(DEV_ADDR, tbl_entry_t'(tbl_data));
                    qcnt_d  = '0;
                    state_d = ST_START;
                end
            end
            // Start condition: SIOD low under a high SIOC, then SIOC low for a quarter.
            ST_START: begin
                if (qtick_c) begin
                    unique case (qcnt)
                        2'd0: begin
                            oe_d   = 1'b1;
                            qcnt_d = 2'd1;
                        end
                        2'd1: begin
                            sioc_d = 1'b0;
                            qcnt_d = 2'd2;
                        end
                        default: begin
                            state_d = ST_BITS;
                            qcnt_d  = '0;
                            bit_d   = '0;
                            oe_d    = ~shreg[FRAME_BITS-1];
                        end
                    endcase
                end
            end
            ST_BITS: begin
                if (qtick_c) begin
                    qcnt_d = qcnt + 2'd1;
                    unique case (qcnt)
                        2'd0: sioc_d = 1'b1;
                        2'd1: sioc_d = 1'b1;
                        2'd2: sioc_d = 1'b0;
                        default: begin
                            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                                state_d = ST_STOP;
                                oe_d    = 1'b1;
                            end else begin
                                bit_d = bit_cnt + 5'd1;
                                sh_d  = {shreg[FRAME_BITS-2:0], 1'b1};
                                oe_d  = ~shreg[FRAME_BITS-2];
                            end
                        end
                    endcase
                end
            end
            ST_STOP: begin
                if (qtick_c) begin
                    unique case (qcnt)
                        2'd0: begin
                            sioc_d = 1'b1;
                            qcnt_d = 2'd1;
                        end
                        2'd1: begin
                            oe_d   = 1'b0;
                            qcnt_d = 2'd2;
                        end
                        default: begin
                            cnt_d   = (reg_count == 8'hFF) ? reg_count : reg_count + 8'd1;
                            qcnt_d  = '0;
                            state_d = ST_GAP;
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (qtick_c) begin
                    if (qcnt == 2'd3) adv = 1'b1;
                    else              qcnt_d = qcnt + 2'd1;
                end
            end
            ST_DELAY: begin
                if (dcnt == DW'(DELAY_CYCLES - 1)) adv = 1'b1;
                else                               dcnt_d = dcnt + DW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Next table entry, or finish when the last index has been consumed.
        if (adv) begin
            if (tbl_addr == AW'(NUM_REGS - 1)) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                addr_d  = tbl_addr + AW'(1);
                state_d = ST_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_cam_sccb_config.sv
// Directed bench for cam_sccb_config: table vectors, bus decoding and corner sequences.
module tb_cam_sccb_config;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        sioc, siod_out, siod_oe, busy, done;
    logic [7:0]  reg_count;
    logic [1:0]  tbl_addr2;
    logic [15:0] tbl_data2;
    logic        sioc2, siod_out2, siod_oe2, busy2, done2;
    logic [7:0]  reg_count2;

    logic [15:0] rom  [0:127];
    logic [15:0] rom2 [0:3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    cam_sccb_config #(
        .CLK_HZ(1_600_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
        .NUM_REGS(128), .DELAY_CYCLES(20)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done),
        .reg_count(reg_count)
    );

    cam_sccb_config #(
        .CLK_HZ(1_600_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
        .NUM_REGS(3), .DELAY_CYCLES(20)
    ) dut2 (
        .CLK(CLK), .RST_N(RST_N), .start(start2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
        .sioc(sioc2), .siod_out(siod_out2), .siod_oe(siod_oe2), .busy(busy2), .done(done2),
        .reg_count(reg_count2)
    );

    // Registered ROMs: data follows the address by one clock.
    always @(posedge CLK) begin
        tbl_data  <= rom[tbl_addr];
        tbl_data2 <= rom2[tbl_addr2];
    end

    // Bus monitor state.
    logic        mon_clr = 1'b1;
    int          mon_cyc, mon_frames, mon_nbits, mon_viol, mon_slot_bad;
    int          mon_quiet_min, mon_falls, mon_last_rise, mon_stop_cyc, mon_starts2;
    logic        mon_in;
    logic [7:0]  mon_acc;
    logic [47:0] mon_bytes;
    int unsigned mon_chk;
    logic        p_sioc, p_oe, p_sioc2, p_oe2;

    // Decodes SIOD on SIOC rising edges and flags SIOD changes under a high SIOC.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_clr) begin
                mon_cyc = 0; mon_frames = 0; mon_nbits = 0; mon_viol = 0; mon_slot_bad = 0;
                mon_quiet_min = 1_000_000; mon_falls = 0; mon_last_rise = 0; mon_stop_cyc = 0;
                mon_starts2 = 0; mon_in = 1'b0; mon_acc = '0; mon_bytes = '0; mon_chk = 0;
            end else begin
                mon_cyc++;
                mon_chk = mon_chk * 31 + {30'd0, sioc, siod_oe};
                if (siod_out !== 1'b0 || siod_out2 !== 1'b0) mon_viol++;
                if (siod_oe != p_oe && (sioc || p_sioc)) begin
                    if (siod_oe && sioc && p_sioc && !mon_in) begin
                        mon_in = 1'b1;
                        mon_nbits = 0;
                        if (mon_frames > 0 && mon_cyc - mon_stop_cyc < mon_quiet_min)
                            mon_quiet_min = mon_cyc - mon_stop_cyc;
                    end else if (!siod_oe && sioc && p_sioc && mon_in && mon_nbits == 27) begin
                        mon_in = 1'b0;
                        mon_frames++;
                        mon_stop_cyc = mon_cyc;
                    end else begin
                        mon_viol++;
                    end
                end
                if (!sioc && p_sioc) mon_falls++;
                if (sioc && !p_sioc && mon_in && mon_nbits < 27) begin
                    int bidx;
                    if (mon_nbits > 0 && mon_cyc - mon_last_rise != 16) mon_slot_bad++;
                    mon_last_rise = mon_cyc;
                    if (mon_nbits % 9 < 8) mon_acc = {mon_acc[6:0], ~siod_oe};
                    bidx = mon_frames * 3 + mon_nbits / 9;
                    if (mon_nbits % 9 == 7 && bidx < 6) mon_bytes[47 - 8*bidx -: 8] = mon_acc;
                    mon_nbits++;
                end
                if (siod_oe2 && !p_oe2 && sioc2 && p_sioc2) mon_starts2++;
            end
            p_sioc = sioc; p_oe = siod_oe; p_sioc2 = sioc2; p_oe2 = siod_oe2;
        end
    end

    typedef struct {
        logic [63:0] tbl;
        int          frames;
        logic [47:0] bytes;
        int          rc;
        int          addr;
        int          cycles;
    } vec_t;

    vec_t        vecs [4];
    int unsigned chk0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic load_rom(input logic [63:0] t);
        for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF;
        rom[0] = t[63:48]; rom[1] = t[47:32]; rom[2] = t[31:16]; rom[3] = t[15:0];
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge CLK);
            #1 cyc++;
        end
    endtask

    task automatic wait_nbits(input int n);
        int k = 0;
        while (!(mon_in && mon_nbits >= n) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        check($sformatf("reach bit %0d", n), (mon_in && mon_nbits >= n) ? 1 : 0, 1);
    endtask

    task automatic run_vec(input int i, input bit glitch);
        int    cyc;
        string p;
        p = $sformatf("v%0d%s", i, glitch ? "g" : "");
        load_rom(vecs[i].tbl);
        clear_mon();
        pulse_start();
        if (glitch) begin
            wait_nbits(11);
            pulse_start();
            check({p, " busy after ignored start"}, int'(busy), 1);
        end
        wait_done(cyc);
        if (!glitch) check({p, " cycles to done"}, cyc, vecs[i].cycles);
        check({p, " done"}, int'(done), 1);
        check({p, " busy"}, int'(busy), 0);
        check({p, " reg_count"}, int'(reg_count), vecs[i].rc);
        check({p, " tbl_addr"}, int'(tbl_addr), vecs[i].addr);
        check({p, " frames"}, mon_frames, vecs[i].frames);
        check({p, " bytes frame0"}, int'(mon_bytes[47:24]), int'(vecs[i].bytes[47:24]));
        check({p, " bytes frame1"}, int'(mon_bytes[23:0]), int'(vecs[i].bytes[23:0]));
        check({p, " sioc falls"}, mon_falls, 28 * vecs[i].frames);
        check({p, " bus violations"}, mon_viol, 0);
        check({p, " slot length"}, mon_slot_bad, 0);
        check({p, " idle bus"}, int'({sioc, siod_oe}), 2);
        if (vecs[i].frames == 2) check({p, " quiet >= 20"}, (mon_quiet_min >= 20) ? 1 : 0, 1);
    endtask

    initial begin
        int cyc;
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{64'h1280_F0F0_1101_FFFF, 2, 48'h42_12_80_42_11_01, 2, 3, 971};
        vecs[1] = '{64'hFFFF_1280_1280_1280, 0, 48'h0,                 0, 0, 3};
        vecs[2] = '{64'hA5C3_FFFF_0000_0000, 1, 48'h42_A5_C3_00_00_00, 1, 1, 475};
        vecs[3] = '{64'hF0F0_FFFF_1280_1280, 0, 48'h0,                 0, 1, 26};
        rom2[0] = 16'h1280; rom2[1] = 16'h1101; rom2[2] = 16'h1234; rom2[3] = 16'h5555;
        load_rom(64'hFFFF_FFFF_FFFF_FFFF);

        // Reset values, and no self-start after release.
        repeat (3) @(posedge CLK);
        #1;
        check("rst sioc", int'(sioc), 1);
        check("rst siod_oe", int'(siod_oe), 0);
        check("rst siod_out", int'(siod_out), 0);
        check("rst busy/done", int'({busy, done}), 0);
        check("rst reg_count", int'(reg_count), 0);
        check("rst tbl_addr", int'(tbl_addr), 0);
        RST_N = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("no auto start", int'({busy, done, sioc}), 1);

        for (int i = 0; i < 4; i++) begin
            run_vec(i, 1'b0);
            if (i == 0) chk0 = mon_chk;
        end

        // Start pulsed mid-transfer must leave the waveform untouched.
        run_vec(0, 1'b1);
        check("glitch waveform", int'(mon_chk == chk0), 1);

        // Asynchronous reset during bit 5, then a clean replay from index 0.
        load_rom(vecs[0].tbl);
        clear_mon();
        pulse_start();
        wait_nbits(6);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("midrst sioc", int'(sioc), 1);
        check("midrst siod_oe", int'(siod_oe), 0);
        check("midrst busy/done", int'({busy, done}), 0);
        check("midrst tbl_addr", int'(tbl_addr), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        run_vec(0, 1'b0);

        // Three-entry table without an end marker.
        clear_mon();
        @(posedge CLK);
        #1 start2 = 1'b1;
        @(posedge CLK);
        #1 start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 4000) begin
            @(posedge CLK);
            #1 cyc++;
        end
        check("nr3 done", int'(done2), 1);
        check("nr3 reg_count", int'(reg_count2), 3);
        check("nr3 writes", mon_starts2, 3);
        check("nr3 tbl_addr", int'(tbl_addr2), 2);
        check("nr3 violations", mon_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
